// File: rtl/rv32i_instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_encode_pkg
// Brief    : Instruction kinds, RV32I opcode fields, error codes, loader states.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_encode_pkg;

    typedef enum logic [3:0] {
        KIND_ADDI = 4'd0,
        KIND_ADD  = 4'd1,
        KIND_SUB  = 4'd2,
        KIND_AND  = 4'd3,
        KIND_XOR  = 4'd4,
        KIND_BEQ  = 4'd5,
        KIND_BNE  = 4'd6,
        KIND_JAL  = 4'd7,
        KIND_JALR = 4'd8,
        KIND_LUI  = 4'd9,
        KIND_SB   = 4'd10,
        KIND_LBU  = 4'd11
    } op_kind_t;

    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_AND  = 3'b111;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_JALR = 3'b000;
    localparam logic [2:0] c_F3_SB   = 3'b000;
    localparam logic [2:0] c_F3_LBU  = 3'b100;

    localparam logic [6:0] c_F7_BASE = 7'h00;
    localparam logic [6:0] c_F7_SUB  = 7'h20;

    localparam logic [1:0] c_ERR_NONE = 2'd0;
    localparam logic [1:0] c_ERR_KIND = 2'd1;
    localparam logic [1:0] c_ERR_IMM  = 2'd2;
    localparam logic [1:0] c_ERR_OVF  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_instr_encoder_loader_if
// Brief    : Request stream, instruction-memory write port and load status.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32i_instr_encoder_loader_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  start;
    logic                  op_valid;
    logic                  op_ready;
    logic                  op_last;
    logic [3:0]            op_kind;
    logic [4:0]            op_rd;
    logic [4:0]            op_rs1;
    logic [4:0]            op_rs2;
    logic [31:0]           op_imm;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;
    logic [ADDR_WIDTH-1:0] word_count;

    modport master (
        output start, op_valid, op_last, op_kind, op_rd, op_rs1, op_rs2, op_imm,
        input  op_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, word_count
    );

    modport slave (
        input  start, op_valid, op_last, op_kind, op_rd, op_rs1, op_rs2, op_imm,
        output op_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, word_count
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_instr_encoder_loader_encode.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_instr_encode
// Brief    : Combinational symbolic-op to RV32I machine-word encoder.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_instr_encode
    import rv32i_encode_pkg::*;
(
    input  wire logic [3:0]  kind_i,
    input  wire logic [4:0]  rd_i,
    input  wire logic [4:0]  rs1_i,
    input  wire logic [4:0]  rs2_i,
    input  wire logic [31:0] imm_i,
    output logic [31:0]      word_o,
    output logic             illegal_kind_o,
    output logic             imm_bad_o
);
    logic w_i_ok;
    logic w_b_ok;
    logic w_j_ok;
    logic w_u_ok;

    // A value fits N signed bits when every bit above the sign bit copies it.
    assign w_i_ok = (imm_i[31:11] == {21{imm_i[11]}});
    assign w_b_ok = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
    assign w_j_ok = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];
    assign w_u_ok = (imm_i[11:0] == 12'd0);

    always_comb begin
        word_o         = '0;
        illegal_kind_o = 1'b0;
        imm_bad_o      = 1'b0;
        case (kind_i)
            KIND_ADDI: begin
                word_o    = {imm_i[11:0], rs1_i, c_F3_ADD, rd_i, c_OPC_OP_IMM};
                imm_bad_o = !w_i_ok;
            end
            KIND_ADD: word_o = {c_F7_BASE, rs2_i, rs1_i, c_F3_ADD, rd_i, c_OPC_OP};
            KIND_SUB: word_o = {c_F7_SUB,  rs2_i, rs1_i, c_F3_ADD, rd_i, c_OPC_OP};
            KIND_AND: word_o = {c_F7_BASE, rs2_i, rs1_i, c_F3_AND, rd_i, c_OPC_OP};
            KIND_XOR: word_o = {c_F7_BASE, rs2_i, rs1_i, c_F3_XOR, rd_i, c_OPC_OP};
            KIND_BEQ: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, c_F3_BEQ,
                             imm_i[4:1], imm_i[11], c_OPC_BRANCH};
                imm_bad_o = !w_b_ok;
            end
            KIND_BNE: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, c_F3_BNE,
                             imm_i[4:1], imm_i[11], c_OPC_BRANCH};
                imm_bad_o = !w_b_ok;
            end
            KIND_JAL: begin
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, c_OPC_JAL};
                imm_bad_o = !w_j_ok;
            end
            KIND_JALR: begin
                word_o    = {imm_i[11:0], rs1_i, c_F3_JALR, rd_i, c_OPC_JALR};
                imm_bad_o = !w_i_ok;
            end
            KIND_LUI: begin
                word_o    = {imm_i[31:12], rd_i, c_OPC_LUI};
                imm_bad_o = !w_u_ok;
            end
            KIND_SB: begin
                word_o    = {imm_i[11:5], rs2_i, rs1_i, c_F3_SB, imm_i[4:0], c_OPC_STORE};
                imm_bad_o = !w_i_ok;
            end
            KIND_LBU: begin
                word_o    = {imm_i[11:0], rs1_i, c_F3_LBU, rd_i, c_OPC_LOAD};
                imm_bad_o = !w_i_ok;
            end
            default: illegal_kind_o = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/rv32i_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_instr_encoder_loader
// Brief    : Encodes a stream of symbolic ops and writes them to instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_instr_encoder_loader
    import rv32i_encode_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_WORDS  = 1024
)(
    input  wire logic clk,
    input  wire logic rst,
    rv32i_instr_encoder_loader_if.slave bus
);
    load_state_t           state_q;
    logic                  op_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [1:0]            err_code_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] ptr_q;

    logic [31:0] w_word;
    logic        w_illegal_kind;
    logic        w_imm_bad;
    logic        w_full;
    logic        w_accept;
    logic [1:0]  w_err_code;

    rv32i_instr_encode u_encode (
        .kind_i         (bus.op_kind),
        .rd_i           (bus.op_rd),
        .rs1_i          (bus.op_rs1),
        .rs2_i          (bus.op_rs2),
        .imm_i          (bus.op_imm),
        .word_o         (w_word),
        .illegal_kind_o (w_illegal_kind),
        .imm_bad_o      (w_imm_bad)
    );

    assign w_full   = (count_q == ADDR_WIDTH'(MAX_WORDS));
    assign w_accept = bus.op_valid && op_ready_q;

    always_comb begin
        w_err_code = c_ERR_NONE;
        if (w_illegal_kind)  w_err_code = c_ERR_KIND;
        else if (w_imm_bad)  w_err_code = c_ERR_IMM;
        else if (w_full)     w_err_code = c_ERR_OVF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= c_ERR_NONE;
            count_q      <= '0;
            ptr_q        <= BASE_ADDR;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        state_q    <= ST_LOAD;
                        op_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= c_ERR_NONE;
                        count_q    <= '0;
                        ptr_q      <= BASE_ADDR;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_err_code != c_ERR_NONE) begin
                            // Rejected op: nothing written, pointer and count hold.
                            state_q    <= ST_ERROR;
                            op_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= w_err_code;
                        end else begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= ptr_q;
                            imem_wdata_q <= w_word;
                            ptr_q        <= ptr_q + ADDR_WIDTH'(4);
                            count_q      <= count_q + ADDR_WIDTH'(1);
                            if (bus.op_last) begin
                                state_q    <= ST_FLUSH;
                                op_ready_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    op_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_ready   = op_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.word_count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_rv32i_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_instr_encoder_loader
// Brief    : Directed and random program loads checked against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_instr_encoder_loader;
    localparam int          MAXA   = 1024;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
    localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_DONE = 3, M_ERROR = 4;

    logic clk = 1'b0;
    logic rst;

    rv32i_instr_encoder_loader_if #(.ADDR_WIDTH(32)) ba ();
    rv32i_instr_encoder_loader_if #(.ADDR_WIDTH(32)) bb ();

    rv32i_instr_encoder_loader #(.ADDR_WIDTH(32), .BASE_ADDR(BASE_A), .MAX_WORDS(MAXA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ba)
    );

    rv32i_instr_encoder_loader #(.ADDR_WIDTH(32), .BASE_ADDR(BASE_B), .MAX_WORDS(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bb)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_state;
    int          m_count;
    int          m_code;
    logic [31:0] m_ptr;
    logic [31:0] obs_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoder: field values placed by arithmetic from the ISA rules.
    function automatic void ref_enc(input int k, rd, rs1, rs2, imm,
                                    output logic [31:0] w, output int code);
        bit ok;
        w = 32'h0; code = 0; ok = 1'b1;
        case (k)
            0, 8, 11: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = (imm << 20) | (rs1 << 15) | (rd << 7)
                   | ((k == 11) ? (4 << 12) | 'h03 : (k == 8) ? 'h67 : 'h13);
            end
            1, 2, 3, 4: begin
                w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33
                  | ((k == 2) ? ('h20 << 25) : 0)
                  | ((k == 3) ? (7 << 12) : (k == 4) ? (4 << 12) : 0);
            end
            5, 6: begin
                ok = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25)
                   | (rs2 << 20) | (rs1 << 15) | ((k == 6) ? (1 << 12) : 0)
                   | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
            end
            7: begin
                ok = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12)
                   | (rd << 7) | 'h6F;
            end
            9: begin
                ok = ((imm & 'hFFF) == 0);
                w  = (imm & 32'hFFFF_F000) | (rd << 7) | 'h37;
            end
            10: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15)
                   | ((imm & 'h1F) << 7) | 'h23;
            end
            default: code = 1;
        endcase
        if (code == 0 && !ok) code = 2;
    endfunction

    task automatic tick();
        if (m_state == M_FLUSH) m_state = M_DONE;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "/busy"},  ba.busy,  (m_state == M_LOAD) || (m_state == M_FLUSH));
        check_eq({tag, "/done"},  ba.done,  m_state == M_DONE);
        check_eq({tag, "/err"},   ba.err,   m_state == M_ERROR);
        check_eq({tag, "/code"},  ba.err_code, m_code);
        check_eq({tag, "/count"}, ba.word_count, m_count);
        check_eq({tag, "/ready"}, ba.op_ready, m_state == M_LOAD);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        m_state = M_IDLE; m_count = 0; m_code = 0; m_ptr = BASE_A;
        check_eq({tag, "/we"},    ba.imem_we, 0);
        check_eq({tag, "/addr"},  ba.imem_addr, BASE_A);
        check_eq({tag, "/wdata"}, ba.imem_wdata, 0);
        check_status(tag);
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input string tag);
        bit honoured;
        honoured = (m_state == M_IDLE) || (m_state == M_DONE) || (m_state == M_ERROR);
        ba.start = 1'b1;
        tick();
        ba.start = 1'b0;
        if (honoured) begin
            m_state = M_LOAD; m_count = 0; m_code = 0; m_ptr = BASE_A;
        end
        check_status(tag);
    endtask

    task automatic send_op(input string tag, input int k, rd, rs1, rs2, imm, input bit last);
        logic [31:0] w;
        int          code;
        bit          in_load;
        ref_enc(k, rd, rs1, rs2, imm, w, code);
        if (code == 0 && m_count == MAXA) code = 3;
        in_load     = (m_state == M_LOAD);
        ba.op_valid = 1'b1;
        ba.op_kind  = 4'(k);
        ba.op_rd    = 5'(rd);
        ba.op_rs1   = 5'(rs1);
        ba.op_rs2   = 5'(rs2);
        ba.op_imm   = imm;
        ba.op_last  = last;
        check_eq({tag, "/ready_in"}, ba.op_ready, in_load);
        tick();
        ba.op_valid = 1'b0;
        ba.op_last  = 1'b0;
        obs_wdata   = ba.imem_wdata;
        if (in_load && code == 0) begin
            check_eq({tag, "/we"},    ba.imem_we, 1);
            check_eq({tag, "/addr"},  ba.imem_addr, m_ptr);
            check_eq({tag, "/wdata"}, ba.imem_wdata, w);
            m_ptr   = m_ptr + 32'd4;
            m_count = m_count + 1;
            if (last) m_state = M_FLUSH;
        end else begin
            check_eq({tag, "/we"}, ba.imem_we, 0);
            if (in_load) begin
                m_state = M_ERROR;
                m_code  = code;
            end
        end
        check_status(tag);
    endtask

    task automatic rand_prog(input int n);
        do_start("rand_start");
        for (int i = 0; i < n; i++) begin
            int k;
            int imm;
            if (m_state != M_LOAD) break;
            k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(12, 15))
                                             : int'($urandom_range(0, 11));
            case (k)
                0, 8, 10, 11: imm = int'($urandom_range(0, 4095)) - 2048;
                5, 6:         imm = (int'($urandom_range(0, 8191)) - 4096) & ~1;
                7:            imm = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
                9:            imm = int'($urandom & 32'hFFFF_F000);
                default:      imm = int'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) imm = int'($urandom);
            send_op("rand", k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), imm, i == n - 1);
        end
        tick();
        check_status("rand_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ba.start = 0; ba.op_valid = 0; ba.op_last = 0; ba.op_kind = 0;
        ba.op_rd = 0; ba.op_rs1 = 0; ba.op_rs2 = 0; ba.op_imm = 0;
        bb.start = 0; bb.op_valid = 0; bb.op_last = 0; bb.op_kind = 0;
        bb.op_rd = 0; bb.op_rs1 = 0; bb.op_rs2 = 0; bb.op_imm = 0;
        m_state = M_IDLE; m_count = 0; m_code = 0; m_ptr = BASE_A;

        do_reset("reset");
        check_eq("b_reset/addr",  bb.imem_addr, BASE_B);
        check_eq("b_reset/ready", bb.op_ready, 0);

        // Back-to-back ADDI/ADD/SUB program.
        do_start("p1_start");
        send_op("p1_addi", 0, 1, 0, 0, 5, 0);  check_eq("p1_addi/lit", obs_wdata, 32'h0050_0093);
        send_op("p1_add",  1, 3, 1, 2, 0, 0);  check_eq("p1_add/lit",  obs_wdata, 32'h0020_81B3);
        send_op("p1_sub",  2, 3, 1, 2, 0, 1);  check_eq("p1_sub/lit",  obs_wdata, 32'h4020_81B3);
        tick();
        check_status("p1_done");
        check_eq("p1_done/count", ba.word_count, 3);
        send_op("ignored_in_done", 0, 1, 0, 0, 1, 1);

        do_start("p2_start");
        send_op("p2_xor", 4, 3, 1, 2, 0, 0);            check_eq("p2_xor/lit", obs_wdata, 32'h0020_C1B3);
        send_op("p2_and", 3, 3, 1, 2, 0, 0);            check_eq("p2_and/lit", obs_wdata, 32'h0020_F1B3);
        send_op("p2_lbu", 11, 4, 1, 0, 0, 0);           check_eq("p2_lbu/lit", obs_wdata, 32'h0000_C203);
        send_op("p2_sb", 10, 0, 1, 2, 3, 0);            check_eq("p2_sb/lit",  obs_wdata, 32'h0020_81A3);
        send_op("p2_lui", 9, 5, 0, 0, 32'h1234_5000, 1); check_eq("p2_lui/lit", obs_wdata, 32'h1234_52B7);
        tick();

        do_start("p3_start");
        send_op("p3_beq",  5, 0, 1, 2, -8, 0); check_eq("p3_beq/lit",  obs_wdata, 32'hFE20_8CE3);
        send_op("p3_bne",  6, 0, 1, 2, -8, 0); check_eq("p3_bne/lit",  obs_wdata, 32'hFE20_9CE3);
        send_op("p3_jal",  7, 1, 0, 0, 8, 0);  check_eq("p3_jal/lit",  obs_wdata, 32'h0080_00EF);
        send_op("p3_jalr", 8, 0, 1, 0, 0, 1);  check_eq("p3_jalr/lit", obs_wdata, 32'h0000_8067);
        tick();

        // Immediate boundary values, all legal.
        do_start("bnd_start");
        send_op("bnd_addi_max", 0, 7, 8, 0, 2047, 0);
        send_op("bnd_sb_min", 10, 0, 9, 10, -2048, 0);
        send_op("bnd_beq_max", 5, 0, 3, 4, 4094, 0);
        send_op("bnd_bne_min", 6, 0, 3, 4, -4096, 0);
        send_op("bnd_jal_max", 7, 31, 0, 0, 1048574, 0);
        send_op("bnd_jal_min", 7, 1, 0, 0, -1048576, 1);
        tick();

        // Error handling and priority.
        do_start("e1_start");
        send_op("e1_good", 0, 1, 0, 0, 1, 0);
        send_op("e1_bad",  0, 1, 0, 0, 2048, 0);
        check_eq("e1/code_lit",  ba.err_code, 2);
        check_eq("e1/count_lit", ba.word_count, 1);
        send_op("ignored_in_error", 0, 1, 0, 0, 1, 0);
        do_start("e2_start");
        send_op("e2_kind13", 13, 1, 0, 0, 4096, 0);
        check_eq("e2/code_lit", ba.err_code, 1);
        do_start("e3_start");
        send_op("e3_beq_odd", 5, 0, 1, 2, 3, 0);
        check_eq("e3/code_lit", ba.err_code, 2);
        do_start("e4_start");
        send_op("e4_lui_low", 9, 1, 0, 0, 32'h0000_1001, 0);
        send_op("e4_jal_far", 7, 1, 0, 0, 1048576, 0);

        // start ignored in LOAD, then reset drops the pending state.
        do_start("r_start");
        send_op("r_op1", 1, 1, 2, 3, 0, 0);
        do_start("r_start_in_load");
        send_op("r_op2", 2, 4, 5, 6, 0, 0);
        do_reset("r_reset");
        tick();
        check_eq("r_idle/we", ba.imem_we, 0);
        check_status("r_idle");

        for (int p = 0; p < 12; p++) rand_prog(int'($urandom_range(5, 30)));

        // Capacity overflow and address wrap on the two-word instance.
        bb.start = 1; tick(); bb.start = 0;
        check_eq("b_start/ready", bb.op_ready, 1);
        check_eq("b_start/busy",  bb.busy, 1);
        bb.op_valid = 1; bb.op_kind = 0; bb.op_rd = 1; bb.op_imm = 1; bb.op_last = 0;
        tick();
        check_eq("b_w0/we",    bb.imem_we, 1);
        check_eq("b_w0/addr",  bb.imem_addr, 32'hFFFF_FFFC);
        check_eq("b_w0/wdata", bb.imem_wdata, 32'h0010_0093);
        bb.op_imm = 2;
        tick();
        check_eq("b_w1/we",    bb.imem_we, 1);
        check_eq("b_w1/addr",  bb.imem_addr, 32'h0000_0000);
        check_eq("b_w1/wdata", bb.imem_wdata, 32'h0020_0093);
        check_eq("b_w1/count", bb.word_count, 2);
        bb.op_imm = 3;
        tick();
        check_eq("b_ovf/we",    bb.imem_we, 0);
        check_eq("b_ovf/err",   bb.err, 1);
        check_eq("b_ovf/code",  bb.err_code, 3);
        check_eq("b_ovf/ready", bb.op_ready, 0);
        check_eq("b_ovf/count", bb.word_count, 2);
        bb.op_valid = 0; bb.start = 1;
        tick();
        bb.start = 0;
        check_eq("b_restart/busy",  bb.busy, 1);
        check_eq("b_restart/err",   bb.err, 0);
        check_eq("b_restart/code",  bb.err_code, 0);
        check_eq("b_restart/count", bb.word_count, 0);
        check_eq("b_restart/ready", bb.op_ready, 1);
        bb.op_valid = 1; bb.op_imm = 4; bb.op_last = 1;
        tick();
        bb.op_valid = 0; bb.op_last = 0;
        check_eq("b_last/we",    bb.imem_we, 1);
        check_eq("b_last/addr",  bb.imem_addr, 32'hFFFF_FFFC);
        check_eq("b_last/wdata", bb.imem_wdata, 32'h0040_0093);
        check_eq("b_last/busy",  bb.busy, 1);
        tick();
        check_eq("b_done/done", bb.done, 1);
        check_eq("b_done/busy", bb.busy, 0);
        check_eq("b_done/we",   bb.imem_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
